// File: rtl/tile_matmul_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tile_matmul_ctrl : tiled INT8 C = (A + offset) * B controller driving a  |
// | PxP systolic array. TILE_MATMUL_ACCUM_EN enables accumulate-into-C mode. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tile_matmul_ctrl #(
   parameter int ARRAY_DIM = 4,
   parameter int ACC_W     = 32,
   parameter int IDX_W     = 16,
   parameter int DIM_W     = 8
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 in_valid,
   input  logic [DIM_W-1:0]                     K,
   input  logic [DIM_W-1:0]                     M,
   input  logic [DIM_W-1:0]                     N,
   input  logic signed [8:0]                    input_offset,
   input  logic                                 accumulate,
   output logic                                 busy,
   output logic                                 done,
   output logic [IDX_W-1:0]                     A_index,
   output logic                                 A_wr_en,
   output logic [8*ARRAY_DIM-1:0]               A_data_in,
   input  logic [8*ARRAY_DIM-1:0]               A_data_out,
   output logic [IDX_W-1:0]                     B_index,
   output logic                                 B_wr_en,
   output logic [8*ARRAY_DIM-1:0]               B_data_in,
   input  logic [8*ARRAY_DIM-1:0]               B_data_out,
   output logic                                 C_wr_en,
   output logic [IDX_W-1:0]                     C_index,
   output logic [ARRAY_DIM*ACC_W-1:0]           C_data_in,
   input  logic [ARRAY_DIM*ACC_W-1:0]           C_data_out,
   output logic                                 sa_clear,
   output logic                                 sa_in_valid,
   output logic [ARRAY_DIM*8*ARRAY_DIM-1:0]     sa_row_in,
   output logic [ARRAY_DIM*8*ARRAY_DIM-1:0]     sa_col_in,
   output logic signed [8:0]                    sa_input_offset,
   input  logic                                 sa_busy,
   input  logic [ARRAY_DIM*ARRAY_DIM*ACC_W-1:0] sa_data_out
);
   localparam int P      = ARRAY_DIM;
   localparam int WORD_W = 8 * P;
   localparam int ROW_W  = P * ACC_W;
   localparam int CW     = (P > 1) ? $clog2(P) : 1;
   localparam int KW     = DIM_W + 1;
   localparam int RW     = DIM_W + 2;

   typedef enum logic [3:0] {
      IDLE       = 4'd0,
      CLEAR      = 4'd1,
      CLEAR_WAIT = 4'd2,
      RD_ADDR    = 4'd3,
      RD_DATA    = 4'd4,
      SA_START   = 4'd5,
      SA_WAIT    = 4'd6,
      C_RD       = 4'd7,
      C_WR       = 4'd8,
      NEXT_TILE  = 4'd9,
      DONE       = 4'd10
   } state_t;

   state_t             r_state;
   logic [DIM_W-1:0]   r_k, r_m, r_n, r_tr, r_tc;
   logic [KW-1:0]      r_k0;
   logic [CW-1:0]      r_j, r_i;
   logic               r_acc;
   logic [P*ROW_W-1:0] r_result;

   logic [KW-1:0]      w_k_cur, w_k0_next;
   logic [RW-1:0]      w_tr_base, w_tc_base, w_row_next;
   logic               w_tr_more, w_tc_more;
   logic [WORD_W-1:0]  w_a_lanes, w_b_lanes;
   logic [ROW_W-1:0]   w_rows [P];
   logic [ROW_W-1:0]   w_row;

   assign A_wr_en   = 1'b0;
   assign A_data_in = '0;
   assign B_wr_en   = 1'b0;
   assign B_data_in = '0;

   assign w_k_cur    = r_k0 + KW'(r_j);
   assign w_k0_next  = r_k0 + KW'(P);
   assign w_tr_base  = RW'(r_tr) * RW'(P);
   assign w_tc_base  = RW'(r_tc) * RW'(P);
   assign w_row_next = w_tr_base + RW'(r_i) + RW'(1);
   assign w_tr_more  = (w_tr_base + RW'(P)) < RW'(r_m);
   assign w_tc_more  = (w_tc_base + RW'(P)) < RW'(r_n);
   assign w_row      = w_rows[r_i];

   // Lanes outside M (A rows) or N (B columns) enter the array as zero.
   for (genvar g = 0; g < P; g++) begin : g_lane
      assign w_a_lanes[(P-1-g)*8 +: 8] = ((w_tr_base + RW'(g)) < RW'(r_m)) ?
                                         A_data_out[(P-1-g)*8 +: 8] : 8'd0;
      assign w_b_lanes[(P-1-g)*8 +: 8] = ((w_tc_base + RW'(g)) < RW'(r_n)) ?
                                         B_data_out[(P-1-g)*8 +: 8] : 8'd0;
      assign w_rows[g] = r_result[(P-1-g)*ROW_W +: ROW_W];
   end

`ifdef TILE_MATMUL_ACCUM_EN
   logic [ROW_W-1:0] w_sum;
   for (genvar g = 0; g < P; g++) begin : g_acc_lane
      assign w_sum[g*ACC_W +: ACC_W] = w_row[g*ACC_W +: ACC_W] + C_data_out[g*ACC_W +: ACC_W];
   end
   assign C_data_in = C_wr_en ? (r_acc ? w_sum : w_row) : '0;
`else
   logic w_unused_ok;
   assign w_unused_ok = &{1'b0, accumulate, C_data_out};
   assign C_data_in   = C_wr_en ? w_row : '0;
`endif

   function automatic logic [IDX_W-1:0] f_ab_idx(input logic [DIM_W-1:0] tile,
                                                 input logic [DIM_W-1:0] kdim,
                                                 input logic [KW-1:0]    kk);
      return IDX_W'(tile) * IDX_W'(kdim) + IDX_W'(kk);
   endfunction

   function automatic logic [IDX_W-1:0] f_c_idx(input logic [DIM_W-1:0] tc,
                                                input logic [DIM_W-1:0] tr,
                                                input logic [DIM_W-1:0] mdim,
                                                input logic [CW-1:0]    row);
      return IDX_W'(tc) * IDX_W'(mdim) + IDX_W'(tr) * IDX_W'(P) + IDX_W'(row);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= IDLE;
         r_k             <= '0;
         r_m             <= '0;
         r_n             <= '0;
         r_tr            <= '0;
         r_tc            <= '0;
         r_k0            <= '0;
         r_j             <= '0;
         r_i             <= '0;
         r_acc           <= 1'b0;
         r_result        <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         A_index         <= '0;
         B_index         <= '0;
         C_index         <= '0;
         C_wr_en         <= 1'b0;
         sa_clear        <= 1'b0;
         sa_in_valid     <= 1'b0;
         sa_row_in       <= '0;
         sa_col_in       <= '0;
         sa_input_offset <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_k  <= K;
                  r_m  <= M;
                  r_n  <= N;
                  r_tr <= '0;
                  r_tc <= '0;
`ifdef TILE_MATMUL_ACCUM_EN
                  r_acc <= accumulate;
`else
                  r_acc <= 1'b0;
`endif
                  if (K == '0 || M == '0 || N == '0) begin
                     done    <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     busy            <= 1'b1;
                     sa_clear        <= 1'b1;
                     sa_input_offset <= input_offset;
                     r_state         <= CLEAR;
                  end
               end
            end
            CLEAR: begin
               sa_clear <= 1'b0;
               r_k0     <= '0;
               r_state  <= CLEAR_WAIT;
            end
            CLEAR_WAIT: begin
               if (!sa_busy) begin
                  r_j     <= '0;
                  A_index <= f_ab_idx(r_tr, r_k, r_k0);
                  B_index <= f_ab_idx(r_tc, r_k, r_k0);
                  r_state <= RD_ADDR;
               end
            end
            RD_ADDR: r_state <= RD_DATA;
            RD_DATA: begin
               // k beyond K pads the chunk with zero words
               if (w_k_cur < KW'(r_k)) begin
                  sa_row_in[(P-1-int'(r_j))*WORD_W +: WORD_W] <= w_a_lanes;
                  sa_col_in[(P-1-int'(r_j))*WORD_W +: WORD_W] <= w_b_lanes;
               end else begin
                  sa_row_in[(P-1-int'(r_j))*WORD_W +: WORD_W] <= '0;
                  sa_col_in[(P-1-int'(r_j))*WORD_W +: WORD_W] <= '0;
               end
               if (r_j == CW'(P-1)) begin
                  sa_in_valid <= 1'b1;
                  r_state     <= SA_START;
               end else begin
                  r_j     <= r_j + CW'(1);
                  A_index <= f_ab_idx(r_tr, r_k, w_k_cur + KW'(1));
                  B_index <= f_ab_idx(r_tc, r_k, w_k_cur + KW'(1));
                  r_state <= RD_ADDR;
               end
            end
            SA_START: begin
               sa_in_valid <= 1'b0;
               r_state     <= SA_WAIT;
            end
            SA_WAIT: begin
               if (!sa_busy) begin
                  if (w_k0_next < KW'(r_k)) begin
                     r_k0    <= w_k0_next;
                     r_j     <= '0;
                     A_index <= f_ab_idx(r_tr, r_k, w_k0_next);
                     B_index <= f_ab_idx(r_tc, r_k, w_k0_next);
                     r_state <= RD_ADDR;
                  end else begin
                     r_result <= sa_data_out;
                     r_i      <= '0;
                     C_index  <= f_c_idx(r_tc, r_tr, r_m, '0);
                     if (r_acc) begin
                        r_state <= C_RD;
                     end else begin
                        C_wr_en <= 1'b1;
                        r_state <= C_WR;
                     end
                  end
               end
            end
            C_RD: begin
               C_wr_en <= 1'b1;
               r_state <= C_WR;
            end
            C_WR: begin
               C_wr_en <= 1'b0;
               if (r_i != CW'(P-1) && w_row_next < RW'(r_m)) begin
                  r_i     <= r_i + CW'(1);
                  C_index <= f_c_idx(r_tc, r_tr, r_m, r_i + CW'(1));
                  if (r_acc) begin
                     r_state <= C_RD;
                  end else begin
                     C_wr_en <= 1'b1;
                     r_state <= C_WR;
                  end
               end else begin
                  r_state <= NEXT_TILE;
               end
            end
            NEXT_TILE: begin
               if (w_tr_more) begin
                  r_tr     <= r_tr + DIM_W'(1);
                  sa_clear <= 1'b1;
                  r_state  <= CLEAR;
               end else if (w_tc_more) begin
                  r_tr     <= '0;
                  r_tc     <= r_tc + DIM_W'(1);
                  sa_clear <= 1'b1;
                  r_state  <= CLEAR;
               end else begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               done    <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_tile_matmul_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tile_matmul_ctrl : self-checking bench with buffer and array models.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_tile_matmul_ctrl;
   typedef struct {int k; int m; int n; int off; int acc; int pat; int exp_wr;} vec_t;
   typedef struct packed {logic [15:0] idx; logic [127:0] data;} wr_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic in_valid = 1'b0;
   logic [7:0] K = '0, M = '0, N = '0;
   logic signed [8:0] input_offset = '0;
   logic accumulate = 1'b0;
   logic busy, done, A_wr_en, B_wr_en, C_wr_en, sa_clear, sa_in_valid;
   logic [15:0] A_index, B_index, C_index;
   logic [31:0] A_data_in, B_data_in;
   logic [31:0] A_data_out = '0, B_data_out = '0;
   logic [127:0] C_data_in;
   logic [127:0] C_data_out = '0;
   logic [127:0] sa_row_in, sa_col_in;
   logic signed [8:0] sa_input_offset;
   logic sa_busy = 1'b0;
   logic [511:0] sa_data_out = '0;

   logic [31:0]  a_mem [256];
   logic [31:0]  b_mem [256];
   logic [127:0] c_mem [256];
   int amat [16][16];
   int bmat [16][16];
   int acc_m [4][4];
   int sa_cnt = 0;

   wr_t exp_q[$];
   wr_t obs_q[$];
   int done_cnt = 0, clr_cnt = 0, siv_cnt = 0, ab_wr_cnt = 0;
   int total = 0, bad = 0;
   vec_t vecs[6];

   tile_matmul_ctrl #(.ARRAY_DIM(4), .ACC_W(32), .IDX_W(16), .DIM_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .K(K), .M(M), .N(N),
      .input_offset(input_offset), .accumulate(accumulate), .busy(busy), .done(done),
      .A_index(A_index), .A_wr_en(A_wr_en), .A_data_in(A_data_in), .A_data_out(A_data_out),
      .B_index(B_index), .B_wr_en(B_wr_en), .B_data_in(B_data_in), .B_data_out(B_data_out),
      .C_wr_en(C_wr_en), .C_index(C_index), .C_data_in(C_data_in), .C_data_out(C_data_out),
      .sa_clear(sa_clear), .sa_in_valid(sa_in_valid), .sa_row_in(sa_row_in),
      .sa_col_in(sa_col_in), .sa_input_offset(sa_input_offset), .sa_busy(sa_busy),
      .sa_data_out(sa_data_out)
   );

   always #5 clk = ~clk;

   // Buffers: registered read, data valid one cycle after the index.
   always @(posedge clk) begin
      A_data_out <= a_mem[A_index[7:0]];
      B_data_out <= b_mem[B_index[7:0]];
      C_data_out <= c_mem[C_index[7:0]];
      if (C_wr_en) c_mem[C_index[7:0]] <= C_data_in;
   end

   // Systolic array: accumulates (a + offset) * b, busy for a few cycles per command.
   always @(posedge clk) begin
      logic signed [7:0] av, bv;
      logic [511:0] q;
      if (sa_clear) begin
         for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) acc_m[r][c] = 0;
         sa_cnt = 2;
      end else if (sa_in_valid) begin
         for (int j = 0; j < 4; j++)
            for (int r = 0; r < 4; r++)
               for (int c = 0; c < 4; c++) begin
                  av = sa_row_in[(3-j)*32 + (3-r)*8 +: 8];
                  bv = sa_col_in[(3-j)*32 + (3-c)*8 +: 8];
                  acc_m[r][c] += (int'(av) + int'(sa_input_offset)) * int'(bv);
               end
         sa_cnt = 3;
      end else if (sa_cnt > 0) begin
         sa_cnt--;
      end
      q = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) q[(3-r)*128 + (3-c)*32 +: 32] = 32'(acc_m[r][c]);
      sa_busy     <= (sa_cnt > 0);
      sa_data_out <= q;
   end

   always @(negedge clk) begin
      if (C_wr_en) obs_q.push_back('{idx: C_index, data: C_data_in});
      if (done) done_cnt++;
      if (sa_clear) clr_cnt++;
      if (sa_in_valid) siv_cnt++;
      if (A_wr_en || B_wr_en) ab_wr_cnt++;
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // pat: 0 = identity A / B = 1..16, 1 = random int8, 2 = all ones with C preloaded to 100.
   task automatic build_job(input int k, input int m, input int n, input int off,
                            input int pat, input int acc_eff);
      logic [31:0]  w;
      logic [127:0] d;
      int s, row, col;
      int tm = (m + 3) / 4;
      int tn = (n + 3) / 4;
      for (int a = 0; a < 256; a++) begin
         a_mem[a] = '0;
         b_mem[a] = '0;
         c_mem[a] = (pat == 2) ? {4{32'd100}} : '0;
      end
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++) begin
            amat[r][c] = (pat == 0) ? ((r == c) ? 1 : 0) : (pat == 2) ? 1 :
                         int'($urandom_range(0, 255)) - 128;
            bmat[r][c] = (pat == 0) ? (r * 4 + c + 1) : (pat == 2) ? 1 :
                         int'($urandom_range(0, 255)) - 128;
         end
      for (int t = 0; t < 4; t++)
         for (int kk = 0; kk < k; kk++) begin
            if (t < tm) begin
               w = '0;
               for (int r = 0; r < 4; r++) if (t * 4 + r < m) w[(3-r)*8 +: 8] = 8'(amat[t*4+r][kk]);
               a_mem[t*k+kk] = w;
            end
            if (t < tn) begin
               w = '0;
               for (int c = 0; c < 4; c++) if (t * 4 + c < n) w[(3-c)*8 +: 8] = 8'(bmat[kk][t*4+c]);
               b_mem[t*k+kk] = w;
            end
         end
      for (int tc = 0; tc < tn; tc++)
         for (int tr = 0; tr < tm; tr++)
            for (int i = 0; i < 4; i++) begin
               row = tr * 4 + i;
               if (row < m) begin
                  d = '0;
                  for (int c = 0; c < 4; c++) begin
                     col = tc * 4 + c;
                     s = 0;
                     if (col < n) for (int kk = 0; kk < k; kk++) s += (amat[row][kk] + off) * bmat[kk][col];
                     if (acc_eff != 0) s += 100;
                     d[(3-c)*32 +: 32] = 32'(s);
                  end
                  exp_q.push_back('{idx: 16'(tc * m + tr * 4 + i), data: d});
               end
            end
   endtask

   task automatic run_job(input vec_t v, input bit disturb);
      int base, dbase, n;
      bit fin;
      wr_t e;
      int acc_eff;
`ifdef TILE_MATMUL_ACCUM_EN
      acc_eff = v.acc;
`else
      acc_eff = 0;
`endif
      exp_q.delete();
      build_job(v.k, v.m, v.n, v.off, v.pat, acc_eff);
      base  = obs_q.size();
      dbase = done_cnt;
      @(negedge clk);
      K = 8'(v.k); M = 8'(v.m); N = 8'(v.n);
      input_offset = 9'(v.off);
      accumulate = v.acc[0];
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("start_busy", busy, 1);
      chk("start_clear", sa_clear, 1);
      in_valid = 1'b0;
      K = 8'($urandom); M = 8'($urandom); N = 8'($urandom);
      input_offset = 9'($urandom);
      fin = 1'b0;
      for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
         @(posedge clk); #1;
         if (done) fin = 1'b1;
         if (disturb) begin
            in_valid = (cyc >= 2 && cyc < 10);
            K = 8'd8;
         end
      end
      in_valid = 1'b0;
      chk("done_seen", fin, 1);
      chk("done_busy_low", busy, 0);
      @(posedge clk); #1;
      chk("done_one_cycle", done, 0);
      chk("wr_count", obs_q.size() - base, v.exp_wr);
      n = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (base + n < obs_q.size()) begin
            chk("c_index", obs_q[base+n].idx, e.idx);
            chk("c_data", obs_q[base+n].data, e.data);
         end else begin
            chk("c_wr_missing", 0, 1);
         end
         n++;
      end
      chk("done_count", done_cnt - dbase, 1);
   endtask

   initial begin
      int base, dbase, cbase, sbase;
      logic [15:0] a_snap, b_snap;
      bit fin;

      vecs[0] = '{4, 4, 4,    0, 0, 0, 4};
      vecs[1] = '{5, 6, 3,    3, 0, 1, 6};
      vecs[2] = '{8, 8, 8,   -5, 0, 1, 16};
      vecs[3] = '{1, 1, 1,  127, 0, 1, 1};
      vecs[4] = '{9, 5, 7, -200, 0, 1, 10};
      vecs[5] = '{4, 4, 4,    0, 1, 2, 4};

      for (int a = 0; a < 256; a++) begin a_mem[a] = '0; b_mem[a] = '0; c_mem[a] = '0; end
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_c_wr_en", C_wr_en, 0);
      chk("rst_c_index", C_index, 0);
      chk("rst_a_index", A_index, 0);
      chk("rst_sa_clear", sa_clear, 0);
      chk("rst_sa_in_valid", sa_in_valid, 0);
      chk("rst_sa_row_in", sa_row_in, 0);
      chk("rst_sa_offset", sa_input_offset, 0);
      chk("rst_c_data_in", C_data_in, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 6; v++) run_job(vecs[v], 1'b0);

      // Zero dimension: done at t+1, never busy, no traffic.
      base = obs_q.size(); dbase = done_cnt; cbase = clr_cnt; sbase = siv_cnt;
      a_snap = A_index; b_snap = B_index;
      @(negedge clk);
      K = 8'd0; M = 8'd4; N = 8'd4; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("zero_done_drop", done, 0);
      chk("zero_busy_after", busy, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("zero_no_clear", clr_cnt - cbase, 0);
      chk("zero_no_sa_start", siv_cnt - sbase, 0);
      chk("zero_no_c_wr", obs_q.size() - base, 0);
      chk("zero_a_index", A_index, a_snap);
      chk("zero_b_index", B_index, b_snap);
      chk("zero_done_count", done_cnt - dbase, 1);

      // Start request with K=8 while busy must be ignored.
      run_job('{4, 4, 4, -3, 0, 1, 4}, 1'b1);

      // Asynchronous reset during SA_WAIT aborts the job.
      exp_q.delete();
      build_job(4, 4, 4, 0, 1, 0);
      exp_q.delete();
      @(negedge clk);
      K = 8'd4; M = 8'd4; N = 8'd4; input_offset = '0; accumulate = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      fin = 1'b0;
      for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
         @(posedge clk); #1;
         if (sa_in_valid) fin = 1'b1;
      end
      chk("rst_job_reached_sa", fin, 1);
      @(posedge clk); #2;
      chk("rst_job_in_sa_wait", busy && !sa_in_valid && !C_wr_en, 1);
      base = obs_q.size();
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_sa_clear", sa_clear, 0);
      chk("abort_sa_in_valid", sa_in_valid, 0);
      chk("abort_c_wr_en", C_wr_en, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_no_c_wr", obs_q.size() - base, 0);
      chk("abort_stays_idle", busy, 0);
      run_job('{4, 4, 4, 7, 0, 1, 4}, 1'b0);

      chk("ab_never_written", ab_wr_cnt, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
